// File: rtl/mm_display_ctrl.sv
// mm_display_ctrl
// Sequencer and state owner for the four-slot RGB LED display of the
// code-guessing game. Holds the in-progress guess and cursor, a circular
// history of submitted codes, hands each submitted code to the checker over
// a valid/ready handshake, and generates the slow blink clock.
//
// Ports:
//   clk, rst_n                 system clock, async active-low reset
//   btn_left/right/color/
//   btn_submit/btn_mode        single-cycle debounced button pulses
//   submit_ready / submit_valid, submit_code   checker handshake, {s3,s2,s1,s0}
//   blink_clk                  square wave, half-period BLINK_HALF cycles
//   blink_enable, blink_led    cursor blink control and cursor slot
//   guess_rgb0..3              current guess colours
//   history_rgb0..3            selected history entry colours
//   hist_index, hist_count     selected entry (0 = newest), valid entries
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_GUESS   | editing the guess; cursor blinks
// ST_SUBMIT  | code offered to checker, buttons ignored until handshake
// ST_HISTORY | browsing submitted codes; blink disabled
module mm_display_ctrl #(
  parameter int HIST_DEPTH = 8,
  parameter int BLINK_HALF = 12_500_000
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          btn_left,
  input  logic                          btn_right,
  input  logic                          btn_color,
  input  logic                          btn_submit,
  input  logic                          btn_mode,
  input  logic                          submit_ready,
  output logic                          submit_valid,
  output logic [11:0]                   submit_code,
  output logic                          blink_clk,
  output logic                          blink_enable,
  output logic [1:0]                    blink_led,
  output logic [2:0]                    guess_rgb0,
  output logic [2:0]                    guess_rgb1,
  output logic [2:0]                    guess_rgb2,
  output logic [2:0]                    guess_rgb3,
  output logic [2:0]                    history_rgb0,
  output logic [2:0]                    history_rgb1,
  output logic [2:0]                    history_rgb2,
  output logic [2:0]                    history_rgb3,
  output logic [$clog2(HIST_DEPTH)-1:0] hist_index,
  output logic [$clog2(HIST_DEPTH):0]   hist_count
);

  localparam int IW = $clog2(HIST_DEPTH);
  localparam int CW = $clog2(BLINK_HALF);
  localparam logic [CW-1:0] BLINK_LAST = CW'(BLINK_HALF - 1);
  localparam logic [IW:0]   DEPTH      = (IW+1)'(HIST_DEPTH);

  typedef enum logic [1:0] {
    ST_GUESS   = 2'd0,
    ST_SUBMIT  = 2'd1,
    ST_HISTORY = 2'd2
  } state_t;

  state_t        state;
  logic [2:0]    slot [4];
  logic [11:0]   hist_mem [HIST_DEPTH];
  logic [IW-1:0] wr_ptr;
  logic [IW-1:0] rd_addr;
  logic [11:0]   hist_word;
  logic [CW-1:0] blink_cnt;

  // Colour 0 is never produced: 7 wraps back to 1.
  function automatic logic [2:0] color_step(input logic [2:0] c);
    return (c == 3'd7) ? 3'd1 : c + 3'd1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_GUESS;
      blink_enable <= 1'b1;
      blink_led    <= 2'd0;
      submit_valid <= 1'b0;
      submit_code  <= 12'd0;
      wr_ptr       <= '0;
      hist_count   <= '0;
      hist_index   <= '0;
      for (int i = 0; i < 4; i++) slot[i] <= 3'd1;
      for (int i = 0; i < HIST_DEPTH; i++) hist_mem[i] <= 12'd0;
    end else begin
      case (state)
        ST_GUESS: begin
          if (btn_submit) begin
            submit_code  <= {slot[3], slot[2], slot[1], slot[0]};
            submit_valid <= 1'b1;
            state        <= ST_SUBMIT;
          end else if (btn_mode) begin
            if (hist_count != '0) begin
              state        <= ST_HISTORY;
              blink_enable <= 1'b0;
              hist_index   <= '0;
            end
          end else if (btn_color) begin
            slot[blink_led] <= color_step(slot[blink_led]);
          end else if (btn_left) begin
            blink_led <= blink_led - 2'd1;
          end else if (btn_right) begin
            blink_led <= blink_led + 2'd1;
          end
        end
        ST_SUBMIT: begin
          if (submit_ready) begin
            hist_mem[wr_ptr] <= submit_code;
            wr_ptr           <= wr_ptr + 1'b1;
            if (hist_count != DEPTH) hist_count <= hist_count + 1'b1;
            blink_led    <= 2'd0;
            submit_valid <= 1'b0;
            state        <= ST_GUESS;
          end
        end
        ST_HISTORY: begin
          if (btn_mode) begin
            state        <= ST_GUESS;
            blink_enable <= 1'b1;
            hist_index   <= '0;
          end else if (btn_left) begin
            if (({1'b0, hist_index} + (IW+1)'(1)) < hist_count)
              hist_index <= hist_index + 1'b1;
          end else if (btn_right) begin
            if (hist_index != '0) hist_index <= hist_index - 1'b1;
          end
        end
        default: begin
          state        <= ST_GUESS;
          blink_enable <= 1'b1;
          submit_valid <= 1'b0;
        end
      endcase
    end
  end

  // Newest entry sits just behind the write pointer; index counts backwards.
  assign rd_addr = wr_ptr - IW'(1) - hist_index;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hist_word <= 12'd0;
    else        hist_word <= (hist_count == '0) ? 12'd0 : hist_mem[rd_addr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt <= '0;
      blink_clk <= 1'b0;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt <= '0;
      blink_clk <= ~blink_clk;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  assign guess_rgb0   = slot[0];
  assign guess_rgb1   = slot[1];
  assign guess_rgb2   = slot[2];
  assign guess_rgb3   = slot[3];
  assign history_rgb0 = hist_word[2:0];
  assign history_rgb1 = hist_word[5:3];
  assign history_rgb2 = hist_word[8:6];
  assign history_rgb3 = hist_word[11:9];

endmodule

// File: tb/tb_mm_display_ctrl.sv
module tb_mm_display_ctrl;

  localparam int HD = 8;
  localparam int BH = 4;

  localparam logic [4:0] B_NONE = 5'b00000;
  localparam logic [4:0] B_SUB  = 5'b10000;
  localparam logic [4:0] B_MOD  = 5'b01000;
  localparam logic [4:0] B_COL  = 5'b00100;
  localparam logic [4:0] B_LFT  = 5'b00010;
  localparam logic [4:0] B_RGT  = 5'b00001;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        btn_left = 1'b0, btn_right = 1'b0, btn_color = 1'b0;
  logic        btn_submit = 1'b0, btn_mode = 1'b0;
  logic        submit_ready = 1'b0;
  logic        submit_valid;
  logic [11:0] submit_code;
  logic        blink_clk, blink_enable;
  logic [1:0]  blink_led;
  logic [2:0]  guess_rgb0, guess_rgb1, guess_rgb2, guess_rgb3;
  logic [2:0]  history_rgb0, history_rgb1, history_rgb2, history_rgb3;
  logic [2:0]  hist_index;
  logic [3:0]  hist_count;

  int vectors = 0;
  int miscompares = 0;

  mm_display_ctrl #(.HIST_DEPTH(HD), .BLINK_HALF(BH)) dut (
    .clk(clk), .rst_n(rst_n),
    .btn_left(btn_left), .btn_right(btn_right), .btn_color(btn_color),
    .btn_submit(btn_submit), .btn_mode(btn_mode),
    .submit_ready(submit_ready), .submit_valid(submit_valid),
    .submit_code(submit_code), .blink_clk(blink_clk),
    .blink_enable(blink_enable), .blink_led(blink_led),
    .guess_rgb0(guess_rgb0), .guess_rgb1(guess_rgb1),
    .guess_rgb2(guess_rgb2), .guess_rgb3(guess_rgb3),
    .history_rgb0(history_rgb0), .history_rgb1(history_rgb1),
    .history_rgb2(history_rgb2), .history_rgb3(history_rgb3),
    .hist_index(hist_index), .hist_count(hist_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int dut_hist_word();
    return {history_rgb3, history_rgb2, history_rgb1, history_rgb0};
  endfunction

  // ---------------- behavioural model ----------------
  // 0 = guessing, 1 = offering code, 2 = browsing history
  int m_mode;
  int m_g[4];
  int m_cur;
  int m_code;
  int m_valid;
  int m_q[$];       // submitted codes, newest first
  int m_idx;
  int m_hist_exp;   // what the history display shows this cycle
  int m_cyc;        // clock edges since reset release

  function automatic int m_pack();
    return (m_g[3] << 9) | (m_g[2] << 6) | (m_g[1] << 3) | m_g[0];
  endfunction

  function automatic int m_entry();
    return (m_q.size() == 0) ? 0 : m_q[m_idx];
  endfunction

  task automatic m_reset();
    m_mode = 0; m_cur = 0; m_code = 0; m_valid = 0; m_idx = 0;
    m_hist_exp = 0; m_cyc = 0;
    for (int i = 0; i < 4; i++) m_g[i] = 1;
    m_q.delete();
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_reset();
    end else begin
      m_hist_exp = m_entry();
      m_cyc++;
      case (m_mode)
        0: begin
          if (btn_submit) begin
            m_code = m_pack(); m_valid = 1; m_mode = 1;
          end else if (btn_mode) begin
            if (m_q.size() > 0) begin m_mode = 2; m_idx = 0; end
          end else if (btn_color) m_g[m_cur] = (m_g[m_cur] % 7) + 1;
          else if (btn_left)  m_cur = (m_cur + 3) % 4;
          else if (btn_right) m_cur = (m_cur + 1) % 4;
        end
        1: begin
          if (submit_ready) begin
            m_q.push_front(m_code);
            if (m_q.size() > HD) void'(m_q.pop_back());
            m_cur = 0; m_valid = 0; m_mode = 0;
          end
        end
        default: begin
          if (btn_mode) begin m_mode = 0; m_idx = 0; end
          else if (btn_left) begin
            if (m_idx < m_q.size() - 1) m_idx++;
          end else if (btn_right) begin
            if (m_idx > 0) m_idx--;
          end
        end
      endcase
    end
  end

  // ---------------- per-cycle comparison ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      chk("submit_valid", submit_valid, m_valid);
      chk("submit_code", submit_code, m_code);
      chk("blink_clk", blink_clk, (m_cyc / BH) % 2);
      chk("blink_enable", blink_enable, (m_mode != 2) ? 1 : 0);
      chk("blink_led", blink_led, m_cur);
      chk("guess_rgb0", guess_rgb0, m_g[0]);
      chk("guess_rgb1", guess_rgb1, m_g[1]);
      chk("guess_rgb2", guess_rgb2, m_g[2]);
      chk("guess_rgb3", guess_rgb3, m_g[3]);
      chk("history_rgb", dut_hist_word(), m_hist_exp);
      chk("hist_index", hist_index, m_idx);
      chk("hist_count", hist_count, m_q.size());
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic [4:0] b, input logic rdy);
    @(negedge clk);
    {btn_submit, btn_mode, btn_color, btn_left, btn_right} = b;
    submit_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    {btn_submit, btn_mode, btn_color, btn_left, btn_right} = B_NONE;
    submit_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    #1;
    chk("rst guess_rgb0", guess_rgb0, 1);
    chk("rst submit_valid", submit_valid, 0);
    chk("rst hist_count", hist_count, 0);
    repeat (3) @(posedge clk);
    #1 chk("blink after 3", blink_clk, 0);
    @(posedge clk);
    #1 chk("blink after 4", blink_clk, 1);
    repeat (4) @(posedge clk);
    #1 chk("blink after 8", blink_clk, 0);

    // Build slot0=4, slot1=2 and submit with a stalled checker.
    do_reset();
    repeat (3) drive(B_COL, 1'b0);
    drive(B_RGT, 1'b0);
    drive(B_COL, 1'b0);
    drive(B_SUB, 1'b0);
    for (int i = 0; i < 4; i++) begin
      drive(B_NONE, 1'b0);
      chk("held code", submit_code, 12'o1124);
      chk("held valid", submit_valid, 1);
    end
    drive(B_NONE, 1'b1);
    chk("post hs count", hist_count, 1);
    chk("post hs led", blink_led, 0);
    chk("post hs valid", submit_valid, 0);
    drive(B_NONE, 1'b0);
    chk("first entry", dut_hist_word(), 12'o1124);

    drive(B_LFT, 1'b0);
    chk("left wrap", blink_led, 3);
    drive(B_RGT, 1'b0);
    chk("right wrap", blink_led, 0);

    do_reset();
    repeat (7) drive(B_COL, 1'b0);
    chk("colour wrap", guess_rgb0, 1);
    drive(B_COL | B_LFT, 1'b0);
    chk("col+left colour", guess_rgb0, 2);
    chk("col+left cursor", blink_led, 0);
    drive(B_MOD, 1'b0);
    chk("mode empty enable", blink_enable, 1);

    // Nine distinct submissions overflow an 8-deep history.
    do_reset();
    for (int k = 0; k < 9; k++) begin
      drive(B_COL, 1'b0);
      if (k >= 4) begin
        drive(B_RGT, 1'b0);
        drive(B_COL, 1'b0);
      end
      drive(B_SUB, 1'b1);
      drive(B_NONE, 1'b1);
    end
    drive(B_MOD, 1'b0);
    drive(B_NONE, 1'b0);
    chk("full count", hist_count, 8);
    chk("history enable", blink_enable, 0);
    chk("newest entry", dut_hist_word(), 12'o1163);
    repeat (10) drive(B_LFT, 1'b0);
    drive(B_NONE, 1'b0);
    chk("left saturate", hist_index, 7);
    chk("oldest entry", dut_hist_word(), 12'o1113);
    repeat (9) drive(B_RGT, 1'b0);
    chk("right saturate", hist_index, 0);
    drive(B_MOD, 1'b0);
    chk("mode back enable", blink_enable, 1);
    chk("mode back index", hist_index, 0);

    // Asynchronous reset in the middle of an offer.
    drive(B_SUB, 1'b0);
    drive(B_NONE, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("async valid", submit_valid, 0);
    chk("async code", submit_code, 0);
    chk("async count", hist_count, 0);
    chk("async history", dut_hist_word(), 0);
    chk("async guess", {guess_rgb3, guess_rgb2, guess_rgb1, guess_rgb0}, 12'o1111);
    chk("async blink", blink_clk, 0);
    chk("async enable", blink_enable, 1);
    @(negedge clk);
    rst_n = 1'b1;

    for (int n = 0; n < 3000; n++) begin
      logic [4:0] b;
      for (int j = 0; j < 5; j++) b[j] = ($urandom_range(0, 4) == 0);
      drive(b, 1'($urandom_range(0, 1)));
    end

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
